// File: rtl/mux_demux_dir_dato.sv
`default_nettype none
// ============================================================================
//  Module   : mux_demux_dir_dato
//  Purpose  : Address/data multiplexer and read-data demultiplexer for the
//             RTC's shared 8-bit DIR_DATO bus. A register pointer walks a
//             fixed RTC register map whose range is chosen by Control. The
//             block drives the address or the write data onto DIR_DATO and
//             captures read data into the nine IN_* registers.
//  Ports    :
//    reloj, resetM          clock, synchronous active-high reset
//    Inicie, Mod_S          config write data (init, mode/status)
//    OUT_*                  time/date write data
//    Control                00 cfg write, 01 time write, 10 read, 11 idle
//    Status3bit             001 addr, 010 wdata, 101 rdata, else idle
//    enable_cont_32         end-of-bus-cycle pulse (pointer advance)
//    LE                     read latch strobe
//    IN_*                   captured read data
//    Selec_Mux_DDw          current pointer
//    Selec_Demux_DDw        capture destination (pointer or 4'hF)
//    READ                   high in read-data phase
//    DIR_DATO               bidirectional RTC address/data bus
//  Revision : 1.0  initial release
// ============================================================================
module mux_demux_dir_dato (
    input  logic       reloj,
    input  logic       resetM,
    input  logic [7:0] Inicie,
    input  logic [7:0] Mod_S,
    input  logic [7:0] OUT_segh,
    input  logic [7:0] OUT_minh,
    input  logic [7:0] OUT_horah,
    input  logic [7:0] OUT_diaf,
    input  logic [7:0] OUT_mesf,
    input  logic [7:0] OUT_anof,
    input  logic [1:0] Control,
    input  logic [2:0] Status3bit,
    input  logic       enable_cont_32,
    input  logic       LE,
    output logic [7:0] IN_segh,
    output logic [7:0] IN_minh,
    output logic [7:0] IN_horah,
    output logic [7:0] IN_diaf,
    output logic [7:0] IN_mesf,
    output logic [7:0] IN_anof,
    output logic [7:0] IN_segcr,
    output logic [7:0] IN_mincr,
    output logic [7:0] IN_horacr,
    output logic [3:0] Selec_Mux_DDw,
    output logic [3:0] Selec_Demux_DDw,
    output logic       READ,
    inout  wire  [7:0] DIR_DATO
);

    // Bus phases decoded from the timing FSM
    localparam logic [2:0] ST_ADDR  = 3'b001;
    localparam logic [2:0] ST_WDATA = 3'b010;
    localparam logic [2:0] ST_RDATA = 3'b101;

    // Operations
    localparam logic [1:0] CTL_CFG  = 2'b00;
    localparam logic [1:0] CTL_TIME = 2'b01;
    localparam logic [1:0] CTL_READ = 2'b10;

    // First and last index carrying a read destination
    localparam int RD_FIRST = 2;
    localparam int RD_LAST  = 10;

    logic [3:0] ptr_q, ptr_d;
    logic [1:0] ctrl_q;
    logic [7:0] rd_q [RD_FIRST:RD_LAST];
    logic [7:0] bus_out;
    logic       cap_en;
    logic       adv_phase;

    // ------------------------------------------------------------------
    // Range limits per operation; idle (11) pins the pointer at 0.
    // ------------------------------------------------------------------
    function automatic logic [3:0] f_range_start(input logic [1:0] c);
        case (c)
            CTL_TIME, CTL_READ: f_range_start = 4'd2;
            default:            f_range_start = 4'd0;
        endcase
    endfunction

    function automatic logic [3:0] f_range_end(input logic [1:0] c);
        case (c)
            CTL_CFG:  f_range_end = 4'd1;
            CTL_TIME: f_range_end = 4'd7;
            CTL_READ: f_range_end = 4'd10;
            default:  f_range_end = 4'd0;
        endcase
    endfunction

    assign adv_phase = (Status3bit == ST_WDATA) || (Status3bit == ST_RDATA);

    // ------------------------------------------------------------------
    // Pointer next state: an operation change reloads the range start
    // and wins over an advance pulse on the same clock.
    // ------------------------------------------------------------------
    always_comb begin
        ptr_d = ptr_q;
        if (Control != ctrl_q) begin
            ptr_d = f_range_start(Control);
        end else if (enable_cont_32 && adv_phase) begin
            // ">=" keeps the pointer inside the range even if it were
            // ever left outside it.
            if (ptr_q >= f_range_end(ctrl_q)) begin
                ptr_d = f_range_start(ctrl_q);
            end else begin
                ptr_d = ptr_q + 4'd1;
            end
        end
    end

    always_ff @(posedge reloj) begin
        if (resetM) begin
            ptr_q  <= f_range_start(Control);
            ctrl_q <= Control;
        end else begin
            ptr_q  <= ptr_d;
            ctrl_q <= Control;
        end
    end

    // ------------------------------------------------------------------
    // Bus drive: address, write data or zero; released in read phase.
    // ------------------------------------------------------------------
    always_comb begin
        bus_out = 8'h00;
        if (Status3bit == ST_ADDR) begin
            case (ptr_q)
                4'd0:    bus_out = 8'h02;
                4'd1:    bus_out = 8'h00;
                4'd2:    bus_out = 8'h21;
                4'd3:    bus_out = 8'h22;
                4'd4:    bus_out = 8'h23;
                4'd5:    bus_out = 8'h24;
                4'd6:    bus_out = 8'h25;
                4'd7:    bus_out = 8'h26;
                4'd8:    bus_out = 8'h41;
                4'd9:    bus_out = 8'h42;
                4'd10:   bus_out = 8'h43;
                default: bus_out = 8'h00;
            endcase
        end else if (Status3bit == ST_WDATA) begin
            case (ptr_q)
                4'd0:    bus_out = Inicie;
                4'd1:    bus_out = Mod_S;
                4'd2:    bus_out = OUT_segh;
                4'd3:    bus_out = OUT_minh;
                4'd4:    bus_out = OUT_horah;
                4'd5:    bus_out = OUT_diaf;
                4'd6:    bus_out = OUT_mesf;
                4'd7:    bus_out = OUT_anof;
                default: bus_out = 8'h00;
            endcase
        end
    end

    assign READ            = (Status3bit == ST_RDATA);
    assign DIR_DATO        = READ ? 8'hzz : bus_out;
    assign Selec_Mux_DDw   = ptr_q;
    assign Selec_Demux_DDw = READ ? ptr_q : 4'hF;
    assign cap_en          = READ && LE;

    // ------------------------------------------------------------------
    // Read capture: only the register addressed by the pre-update
    // pointer loads; every other one holds.
    // ------------------------------------------------------------------
    generate
        for (genvar k = RD_FIRST; k <= RD_LAST; k++) begin : g_rd
            always_ff @(posedge reloj) begin
                if (resetM) begin
                    rd_q[k] <= 8'h00;
                end else if (cap_en && (ptr_q == 4'(k))) begin
                    rd_q[k] <= DIR_DATO;
                end
            end
        end
    endgenerate

    assign IN_segh   = rd_q[2];
    assign IN_minh   = rd_q[3];
    assign IN_horah  = rd_q[4];
    assign IN_diaf   = rd_q[5];
    assign IN_mesf   = rd_q[6];
    assign IN_anof   = rd_q[7];
    assign IN_segcr  = rd_q[8];
    assign IN_mincr  = rd_q[9];
    assign IN_horacr = rd_q[10];

endmodule
`default_nettype wire

// File: tb/tb_mux_demux_dir_dato.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_demux_dir_dato
//  Purpose  : Directed self-checking bench for mux_demux_dir_dato.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mux_demux_dir_dato;

    logic       reloj = 1'b0;
    logic       resetM;
    logic [7:0] Inicie, Mod_S;
    logic [7:0] OUT_segh, OUT_minh, OUT_horah, OUT_diaf, OUT_mesf, OUT_anof;
    logic [1:0] Control;
    logic [2:0] Status3bit;
    logic       enable_cont_32, LE;
    logic [7:0] IN_segh, IN_minh, IN_horah, IN_diaf, IN_mesf, IN_anof;
    logic [7:0] IN_segcr, IN_mincr, IN_horacr;
    logic [3:0] Selec_Mux_DDw, Selec_Demux_DDw;
    logic       READ;
    wire  [7:0] DIR_DATO;

    logic       drv_en;
    logic [7:0] drv_val;
    assign DIR_DATO = drv_en ? drv_val : 8'hzz;

    always #5 reloj = ~reloj;

    mux_demux_dir_dato dut (
        .reloj(reloj), .resetM(resetM), .Inicie(Inicie), .Mod_S(Mod_S),
        .OUT_segh(OUT_segh), .OUT_minh(OUT_minh), .OUT_horah(OUT_horah),
        .OUT_diaf(OUT_diaf), .OUT_mesf(OUT_mesf), .OUT_anof(OUT_anof),
        .Control(Control), .Status3bit(Status3bit),
        .enable_cont_32(enable_cont_32), .LE(LE),
        .IN_segh(IN_segh), .IN_minh(IN_minh), .IN_horah(IN_horah),
        .IN_diaf(IN_diaf), .IN_mesf(IN_mesf), .IN_anof(IN_anof),
        .IN_segcr(IN_segcr), .IN_mincr(IN_mincr), .IN_horacr(IN_horacr),
        .Selec_Mux_DDw(Selec_Mux_DDw), .Selec_Demux_DDw(Selec_Demux_DDw),
        .READ(READ), .DIR_DATO(DIR_DATO)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Expected IN_* contents: segh, minh, horah, diaf, mesf, anof, segcr, mincr, horacr
    logic [7:0] exp_in [0:8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_in(input string tag);
        logic [7:0] act [0:8];
        act[0] = IN_segh;  act[1] = IN_minh;  act[2] = IN_horah;
        act[3] = IN_diaf;  act[4] = IN_mesf;  act[5] = IN_anof;
        act[6] = IN_segcr; act[7] = IN_mincr; act[8] = IN_horacr;
        for (int i = 0; i < 9; i++)
            chk($sformatf("%s_in%0d", tag, i), {24'd0, act[i]}, {24'd0, exp_in[i]});
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge reloj);
        #1;
    endtask

    task automatic pulse();
        enable_cont_32 = 1'b1;
        tick();
        enable_cont_32 = 1'b0;
    endtask

    initial begin
        resetM = 1'b1; Control = 2'b00; Status3bit = 3'b001;
        enable_cont_32 = 1'b0; LE = 1'b0; drv_en = 1'b0; drv_val = 8'h00;
        Inicie = 8'd10; Mod_S = 8'd20;
        OUT_segh = 8'h11; OUT_minh = 8'h12; OUT_horah = 8'd80;
        OUT_diaf = 8'h14; OUT_mesf = 8'h15; OUT_anof = 8'h16;
        for (int i = 0; i < 9; i++) exp_in[i] = 8'h00;

        // Reset
        repeat (10) tick();
        chk_in("rst");
        chk("rst_ptr",  {28'd0, Selec_Mux_DDw}, 32'd0);
        chk("rst_read", {31'd0, READ}, 32'd0);
        chk("rst_bus",  {24'd0, DIR_DATO}, 32'h02);

        // Config write
        resetM = 1'b0; Status3bit = 3'b010; #1;
        chk("cfg_bus0", {24'd0, DIR_DATO}, 32'd10);
        pulse();
        chk("cfg_ptr1", {28'd0, Selec_Mux_DDw}, 32'd1);
        chk("cfg_bus1", {24'd0, DIR_DATO}, 32'd20);
        pulse();
        chk("cfg_wrap", {28'd0, Selec_Mux_DDw}, 32'd0);
        Status3bit = 3'b001; #1;
        chk("cfg_addr", {24'd0, DIR_DATO}, 32'h02);
        pulse();
        chk("cfg_hold", {28'd0, Selec_Mux_DDw}, 32'd0);

        // Read sweep
        Control = 2'b10; Status3bit = 3'b101;
        tick();
        chk("rd_ptr2",  {28'd0, Selec_Mux_DDw}, 32'd2);
        chk("rd_read",  {31'd0, READ}, 32'd1);
        chk("rd_demux", {28'd0, Selec_Demux_DDw}, 32'd2);
        for (int p = 3; p <= 10; p++) begin
            repeat (31) tick();
            pulse();
            chk($sformatf("rd_step%0d", p), {28'd0, Selec_Mux_DDw}, p);
        end
        repeat (31) tick();
        pulse();
        chk("rd_wrap", {28'd0, Selec_Mux_DDw}, 32'd2);

        // Capture at pointer 3
        pulse();
        chk("cap_ptr3", {28'd0, Selec_Mux_DDw}, 32'd3);
        drv_en = 1'b1; drv_val = 8'h45; LE = 1'b1; #1;
        chk("cap_bus", {24'd0, DIR_DATO}, 32'h45);
        tick();
        LE = 1'b0; drv_en = 1'b0;
        exp_in[1] = 8'h45;
        chk_in("cap");
        // LE in address phase: no capture
        Status3bit = 3'b001; LE = 1'b1; #1;
        chk("cap_addr", {24'd0, DIR_DATO}, 32'h22);
        chk("cap_demuxF", {28'd0, Selec_Demux_DDw}, 32'hF);
        tick();
        LE = 1'b0;
        chk_in("nocap");

        // Time write
        Control = 2'b01; Status3bit = 3'b010;
        tick();
        chk("tw_reload", {28'd0, Selec_Mux_DDw}, 32'd2);
        pulse(); pulse();
        chk("tw_ptr4", {28'd0, Selec_Mux_DDw}, 32'd4);
        chk("tw_data", {24'd0, DIR_DATO}, 32'd80);
        Status3bit = 3'b001; #1;
        chk("tw_addr", {24'd0, DIR_DATO}, 32'h23);

        // Read again: capture segh, then simultaneous LE + advance
        Control = 2'b10; Status3bit = 3'b101;
        tick();
        drv_en = 1'b1; drv_val = 8'h45; LE = 1'b1;
        tick();
        LE = 1'b0; drv_en = 1'b0;
        exp_in[0] = 8'h45;
        chk_in("seg");
        repeat (4) pulse();
        chk("sim_ptr6", {28'd0, Selec_Mux_DDw}, 32'd6);
        drv_en = 1'b1; drv_val = 8'h5A; LE = 1'b1;
        pulse();
        LE = 1'b0; drv_en = 1'b0;
        exp_in[4] = 8'h5A;
        chk("sim_ptr7", {28'd0, Selec_Mux_DDw}, 32'd7);
        chk_in("sim");

        // Reset mid-read at pointer 7
        resetM = 1'b1; LE = 1'b1; enable_cont_32 = 1'b1;
        tick();
        resetM = 1'b0; LE = 1'b0; enable_cont_32 = 1'b0;
        for (int i = 0; i < 9; i++) exp_in[i] = 8'h00;
        chk("mrst_ptr", {28'd0, Selec_Mux_DDw}, 32'd2);
        chk_in("mrst");

        // Idle operation: pointer pinned at 0
        Control = 2'b11; Status3bit = 3'b010;
        tick();
        chk("idle_ptr", {28'd0, Selec_Mux_DDw}, 32'd0);
        pulse();
        chk("idle_hold", {28'd0, Selec_Mux_DDw}, 32'd0);
        Status3bit = 3'b000; #1;
        chk("idle_bus", {24'd0, DIR_DATO}, 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
